femto_tick_gen: RTL and testbench
=================================

FEMTO_TICK_GEN -- requirements
Module: femto_tick_gen

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent tick channels, legal range 1..8.
REQ-002 SHALL have parameter ACC_W, default 24: phase accumulator and increment width in bits, legal range 4..32.
REQ-003 SHALL have parameter LOCK_CYCLES, default 16: settle cycles after reset before ticks run, legal range 1..65535.
REQ-004 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port ch_en, input, CHANNELS: per-channel run enable.
REQ-007 SHALL have port inc_we, input, 1: increment write strobe.
REQ-008 SHALL have port inc_sel, input, 3: channel index for the write.
REQ-009 SHALL have port inc_data, input, ACC_W: increment value to write.
REQ-010 SHALL have port tick, output, CHANNELS: per-channel single-cycle enable pulse.
REQ-011 SHALL have port square, output, CHANNELS: per-channel square wave (see Configuration).
REQ-012 SHALL have port locked, output, 1: high once the settle period has elapsed.

Function
REQ-013 SHALL hold, per channel, an ACC_W-bit increment register inc[c] and an ACC_W-bit accumulator acc[c].
REQ-014 SHALL, on a clk edge with inc_we=1 and inc_sel<CHANNELS, load inc[inc_sel] with inc_data; the new value is used from the next edge.
REQ-015 SHALL ignore writes with inc_sel>=CHANNELS, with no state change.
REQ-016 SHALL leave acc unchanged on a write; phase stays continuous.
REQ-017 SHALL, on each edge with locked=1 and ch_en[c]=1, compute {carry, acc[c]} <= acc[c] + inc[c] as an (ACC_W+1)-bit sum, modulo 2^ACC_W; tick[c] <= carry.
REQ-018 SHALL register tick, giving a latency of one edge: tick is high for exactly the cycle following the overflowing addition.
REQ-019 SHALL, on an edge with ch_en[c]=0 or locked=0, set acc[c] <= 0 and tick[c] <= 0.
REQ-020 SHALL give tick frequency f_clk*inc/2^ACC_W; inc=0 never ticks; inc=2^ACC_W-1 ticks on every edge except the first after enable.
REQ-021 SHALL, when a write to channel c and an accumulation on channel c coincide on the same edge, accumulate with the old inc[c].
REQ-022 SHALL implement lock as a 16-bit counter lock_cnt with two states:
  - SETTLE: lock_cnt increments each edge; at lock_cnt == LOCK_CYCLES-1, locked <= 1 and the state moves to RUN.
  - RUN: terminal state; the counter holds.
REQ-023 SHALL assert locked on the LOCK_CYCLES-th rising edge after reset is sampled low.

Reset
REQ-024 SHALL, on any edge with reset=1, including mid-operation, clear:
  - lock_cnt to 0, state to SETTLE, locked to 0;
  - all acc, inc, tick and square to 0.
REQ-025 SHALL give reset priority over inc_we and ch_en on the same edge.

Configuration
REQ-026 SHALL use macro FEMTO_TICK_SQUARE_EN to control the square output:
  - Defined: square[c] is the registered MSB of acc[c]; it goes low whenever acc[c] is cleared.
  - Undefined: square is constant 0, and the square-wave logic and its registers are absent.
  - The port list is identical in both builds.

Verification
REQ-027 SHALL cover reset released at edge 0 with LOCK_CYCLES=16 -> locked=0 through edge 15 and locked=1 from edge 16; tick=0 throughout.
REQ-028 SHALL cover ACC_W=24, inc[0]=0x800000, ch_en=1 after lock -> tick[0] pulses one cycle in every 2; with FEMTO_TICK_SQUARE_EN, square[0] toggles every edge.
REQ-029 SHALL cover ACC_W=4, inc[1]=1 -> tick[1] high for 1 cycle in every 16; inc[1]=0 -> tick[1] stays 0 for 100 cycles.
REQ-030 SHALL cover inc_sel=5 with CHANNELS=4 -> all inc unchanged; a same-edge write plus accumulation on channel 0 -> that edge uses the old increment.
REQ-031 SHALL cover ch_en[2] dropped mid-run, then raised -> acc[2]=0 and tick[2]=0 while low; the first tick comes inc-period edges after re-enable.
REQ-032 SHALL cover reset pulsed for 1 cycle mid-run -> all outputs 0 on the next edge; locked reasserts exactly LOCK_CYCLES edges later.

Source files
------------

// File: rtl/femto_tick_gen.sv
`default_nettype none
// ============================================================================
// femto_tick_gen : multi-channel phase-accumulator tick/enable generator
// Define FEMTO_TICK_SQUARE_EN to build the per-channel square-wave outputs.
// Revision: 1.0
// ============================================================================
module femto_tick_gen #(
  parameter int CHANNELS    = 4,
  parameter int ACC_W       = 24,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] ch_en,
  input  logic                inc_we,
  input  logic [2:0]          inc_sel,
  input  logic [ACC_W-1:0]    inc_data,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] square,
  output logic                locked
);

  localparam logic [0:0]  C_SETTLE    = 1'b0;
  localparam logic [0:0]  C_RUN       = 1'b1;
  localparam logic [15:0] C_LOCK_LAST = 16'(LOCK_CYCLES - 1);

  logic [0:0]                     state_q, state_d;
  logic [15:0]                    lock_cnt_q, lock_cnt_d;
  logic [CHANNELS-1:0][ACC_W-1:0] inc_q, inc_d;
  logic [CHANNELS-1:0][ACC_W-1:0] acc_q, acc_d;
  logic [CHANNELS-1:0]            tick_q, tick_d;
  logic [ACC_W:0]                 sum;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= C_SETTLE;
      lock_cnt_q <= '0;
      inc_q      <= '0;
      acc_q      <= '0;
      tick_q     <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      inc_q      <= inc_d;
      acc_q      <= acc_d;
      tick_q     <= tick_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      C_SETTLE: begin
        lock_cnt_d = lock_cnt_q + 16'd1;
        if (lock_cnt_q == C_LOCK_LAST) begin
          state_d = C_RUN;
        end
      end
      C_RUN: begin
        lock_cnt_d = lock_cnt_q;
      end
      default: begin
        state_d = C_SETTLE;
      end
    endcase
  end

  always_comb begin
    locked = (state_q == C_RUN);
  end

  // Accumulation reads inc_q, so a same-edge write only takes effect next edge.
  always_comb begin
    inc_d  = inc_q;
    acc_d  = acc_q;
    tick_d = '0;
    sum    = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (locked && ch_en[c]) begin
        sum       = {1'b0, acc_q[c]} + {1'b0, inc_q[c]};
        acc_d[c]  = sum[ACC_W-1:0];
        tick_d[c] = sum[ACC_W];
      end else begin
        acc_d[c] = '0;
      end
      if (inc_we && (inc_sel == 3'(c))) begin
        inc_d[c] = inc_data;
      end
    end
  end

  assign tick = tick_q;

`ifdef FEMTO_TICK_SQUARE_EN
  logic [CHANNELS-1:0] square_q, square_d;

  always_comb begin
    square_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      square_d[c] = acc_d[c][ACC_W-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      square_q <= '0;
    end else begin
      square_q <= square_d;
    end
  end

  assign square = square_q;
`else
  assign square = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_femto_tick_gen.sv
`default_nettype none
// ============================================================================
// tb_femto_tick_gen : scoreboard bench driving an ACC_W=24 and an ACC_W=4 build
// Revision: 1.0
// ============================================================================
module tb_femto_tick_gen;

  localparam int C_CH = 4;
`ifdef FEMTO_TICK_SQUARE_EN
  localparam bit C_SQ_EN = 1'b1;
`else
  localparam bit C_SQ_EN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] ta;
    logic [3:0] tb;
    logic [3:0] sa;
    logic [3:0] sb;
    logic       lk;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  ch_en;
  logic        inc_we;
  logic [2:0]  inc_sel;
  logic [23:0] inc_data_a;
  logic [3:0]  inc_data_b;
  logic [3:0]  tick_a, tick_b, square_a, square_b;
  logic        locked_a, locked_b;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Per-channel accumulation count since acc was last zero, and tick period in edges.
  int         na[C_CH], nb[C_CH], pa[C_CH], pb[C_CH];
  int         lk_cnt;
  logic       lk;
  logic [3:0] en_cur;

  always #5 clk = ~clk;

  femto_tick_gen #(.CHANNELS(4), .ACC_W(24), .LOCK_CYCLES(16)) u_dut_a (
    .clk      (clk),
    .reset    (reset),
    .ch_en    (ch_en),
    .inc_we   (inc_we),
    .inc_sel  (inc_sel),
    .inc_data (inc_data_a),
    .tick     (tick_a),
    .square   (square_a),
    .locked   (locked_a)
  );

  femto_tick_gen #(.CHANNELS(4), .ACC_W(4), .LOCK_CYCLES(16)) u_dut_b (
    .clk      (clk),
    .reset    (reset),
    .ch_en    (ch_en),
    .inc_we   (inc_we),
    .inc_sel  (inc_sel),
    .inc_data (inc_data_b),
    .tick     (tick_b),
    .square   (square_b),
    .locked   (locked_b)
  );

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("tick_a", tick_a, e.ta);
      chk("tick_b", tick_b, e.tb);
      chk("square_a", square_a, e.sa);
      chk("square_b", square_b, e.sb);
      chk("locked_a", {3'b000, locked_a}, {3'b000, e.lk});
      chk("locked_b", {3'b000, locked_b}, {3'b000, e.lk});
    end
  end

  // One clock edge: drive inputs, push the outputs expected after that edge.
  task automatic cyc(input logic rst_i, input logic we_i, input logic [2:0] sel_i,
                     input logic [23:0] da, input logic [3:0] db,
                     input int npa, input int npb);
    exp_t e;
    int   s;
    reset      = rst_i;
    ch_en      = en_cur;
    inc_we     = we_i;
    inc_sel    = sel_i;
    inc_data_a = da;
    inc_data_b = db;
    e = '0;
    if (rst_i) begin
      for (int c = 0; c < C_CH; c++) begin
        na[c] = 0; nb[c] = 0; pa[c] = 0; pb[c] = 0;
      end
      lk_cnt = 0;
      lk     = 1'b0;
    end else begin
      for (int c = 0; c < C_CH; c++) begin
        if (lk && en_cur[c]) begin
          na[c]++; nb[c]++;
        end else begin
          na[c] = 0; nb[c] = 0;
        end
        e.ta[c] = (pa[c] == 0) ? 1'b0 : ((na[c] != 0) && (na[c] % pa[c] == 0));
        e.tb[c] = (pb[c] == 0) ? 1'b0 : ((nb[c] != 0) && (nb[c] % pb[c] == 0));
        e.sa[c] = (pa[c] == 0) ? 1'b0 : (C_SQ_EN && ((na[c] % pa[c]) >= pa[c] / 2));
        e.sb[c] = (pb[c] == 0) ? 1'b0 : (C_SQ_EN && ((nb[c] % pb[c]) >= pb[c] / 2));
      end
      s = int'(sel_i);
      if (we_i && s < C_CH) begin
        pa[s] = npa; pb[s] = npb; na[s] = 0; nb[s] = 0;
      end
      if (lk_cnt < 16) lk_cnt++;
      lk = (lk_cnt >= 16);
    end
    e.lk = lk;
    sb_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic run(input int k);
    repeat (k) cyc(1'b0, 1'b0, 3'd0, 24'h0, 4'h0, 0, 0);
  endtask

  task automatic wr(input logic [2:0] sel, input logic [23:0] da, input logic [3:0] db,
                    input int npa, input int npb);
    cyc(1'b0, 1'b1, sel, da, db, npa, npb);
  endtask

  // Advance until the next edge brings channel c's accumulator back to zero.
  task automatic wait_wrap(input int c);
    int guard = 0;
    while (pa[c] != 0 && ((na[c] + 1) % pa[c]) != 0 && guard < 64) begin
      run(1);
      guard++;
    end
  endtask

  initial begin
    en_cur = 4'h0;
    repeat (3) cyc(1'b1, 1'b0, 3'd0, 24'h0, 4'h0, 0, 0);

    // Settle window: 16 edges, channels enabled but gated by lock.
    en_cur = 4'hF;
    wr(3'd0, 24'h800000, 4'h0, 2, 0);
    wr(3'd1, 24'h100000, 4'h1, 16, 16);
    wr(3'd2, 24'h400000, 4'h4, 4, 4);
    wr(3'd3, 24'h000000, 4'h0, 0, 0);
    wr(3'd5, 24'hFFFFFF, 4'hF, 0, 0);
    wr(3'd4, 24'hFFFFFF, 4'hF, 0, 0);
    run(10);

    run(40);

    // Same-edge write and accumulation on channel 0.
    wait_wrap(0);
    wr(3'd0, 24'h400000, 4'h8, 4, 2);
    run(12);

    // Channel 1 increment to zero: no ticks for 100 cycles.
    wait_wrap(1);
    wr(3'd1, 24'h000000, 4'h0, 0, 0);
    run(100);

    // Channel 2 disabled mid-run, then re-enabled.
    en_cur = 4'b1011;
    run(7);
    en_cur = 4'hF;
    run(12);

    // Single-cycle reset mid-run, then relock.
    cyc(1'b1, 1'b0, 3'd0, 24'h0, 4'h0, 0, 0);
    wr(3'd2, 24'h400000, 4'h4, 4, 4);
    run(15);
    run(12);

    repeat (4) begin
      if (sb_q.size() == 0) break;
      @(posedge clk);
    end
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
